// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI serial command channel: FSM states, frame
// length and the odd-parity helper also used by the drive-side receiver.
package esdi_pkg;

    localparam int ESDI_SERIAL_BITS = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_C_SETUP,
        ST_C_REQ,
        ST_C_REL,
        ST_R_REQ,
        ST_R_REL,
        ST_DONE
    } esdi_state_t;

    // Bit that makes the 17-bit frame {word, bit} contain an odd number of ones.
    function automatic logic odd_parity(input logic [15:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/esdi_sync.sv
// Multi-flop bit synchronizer with asynchronous active-low clear.
module esdi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_sr <= '0;
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], d};
        end
    end

    assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/esdi_serial_cmd_initiator.sv
// Host-side ESDI serial command initiator: sends a 17-bit command frame, then
// optionally reads a 17-bit status word. ESDI_CMD_TIMEOUT_EN adds an ack timeout.
//
// state      | meaning
// IDLE       | ready for a command
// C_SETUP    | command_data driven, waiting out setup time
// C_REQ      | transfer_req high, waiting for ack
// C_REL      | transfer_req low, waiting for ack release
// R_REQ      | response bit request, waiting for ack
// R_REL      | response bit released, waiting for ack release
// DONE       | rsp_valid pulse, back to IDLE
module esdi_serial_cmd_initiator
    import esdi_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 8
`ifdef ESDI_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 125000
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic        cmd_expect_rsp,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_parity_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        transfer_req,
    output logic        command_data,
    input  logic        transfer_ack,
    input  logic        confstat_data
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYCLES - 1);
    localparam logic [4:0] LAST_BIT = 5'(ESDI_SERIAL_BITS - 1);

    esdi_state_t        state;
    logic [15:0]        tx_sr;
    logic [16:0]        rx_sr;
    logic [4:0]         bit_cnt;
    logic [SETUP_W-1:0] setup_cnt;
    logic               expect_rsp;
    logic               ack_s;
    logic               cfg_s;

    esdi_sync #(.STAGES(SYNC_N)) u_sync_ack (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (transfer_ack),
        .q       (ack_s)
    );

    esdi_sync #(.STAGES(SYNC_N)) u_sync_cfg (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (confstat_data),
        .q       (cfg_s)
    );

`ifdef ESDI_CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;
    logic            to_fire;
    logic            rsp_timeout_q;

    // A wait state whose exit condition is not met this cycle keeps counting;
    // anything else reloads, so each handshake wait gets a fresh budget.
    always_comb begin
        waiting = 1'b0;
        case (state)
            ST_C_REQ, ST_R_REQ: waiting = !ack_s;
            ST_C_REL, ST_R_REL: waiting = ack_s;
            default:            waiting = 1'b0;
        endcase
    end

    assign to_fire = waiting && (to_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= TO_LOAD;
        end else if (!waiting) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            tx_sr          <= '0;
            rx_sr          <= '0;
            bit_cnt        <= '0;
            setup_cnt      <= '0;
            expect_rsp     <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            transfer_req   <= 1'b0;
            command_data   <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_parity_err <= 1'b0;
`ifdef ESDI_CMD_TIMEOUT_EN
            rsp_timeout_q  <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx_sr        <= {cmd_word[14:0], odd_parity(cmd_word)};
                        command_data <= cmd_word[15];
                        expect_rsp   <= cmd_expect_rsp;
                        bit_cnt      <= '0;
                        setup_cnt    <= SETUP_LOAD;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_C_SETUP;
                    end
                end
                ST_C_SETUP: begin
                    if (setup_cnt == '0) begin
                        transfer_req <= 1'b1;
                        state        <= ST_C_REQ;
                    end else begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
                end
                ST_C_REQ: begin
                    if (ack_s) begin
                        transfer_req <= 1'b0;
                        state        <= ST_C_REL;
                    end
                end
                ST_C_REL: begin
                    if (!ack_s) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt      <= '0;
                            command_data <= 1'b0;
                            if (expect_rsp) begin
                                transfer_req <= 1'b1;
                                state        <= ST_R_REQ;
                            end else begin
                                rsp_valid      <= 1'b1;
                                rsp_data       <= '0;
                                rsp_parity_err <= 1'b0;
`ifdef ESDI_CMD_TIMEOUT_EN
                                rsp_timeout_q  <= 1'b0;
`endif
                                state          <= ST_DONE;
                            end
                        end else begin
                            command_data <= tx_sr[15];
                            tx_sr        <= {tx_sr[14:0], 1'b0};
                            bit_cnt      <= bit_cnt + 1'b1;
                            setup_cnt    <= SETUP_LOAD;
                            state        <= ST_C_SETUP;
                        end
                    end
                end
                ST_R_REQ: begin
                    // cfg_s and ack_s share synchronizer depth, so data is settled here.
                    if (ack_s) begin
                        rx_sr        <= {rx_sr[15:0], cfg_s};
                        transfer_req <= 1'b0;
                        state        <= ST_R_REL;
                    end
                end
                ST_R_REL: begin
                    if (!ack_s) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt        <= '0;
                            rsp_valid      <= 1'b1;
                            rsp_data       <= rx_sr[16:1];
                            rsp_parity_err <= ~^rx_sr;
`ifdef ESDI_CMD_TIMEOUT_EN
                            rsp_timeout_q  <= 1'b0;
`endif
                            state          <= ST_DONE;
                        end else begin
                            bit_cnt      <= bit_cnt + 1'b1;
                            transfer_req <= 1'b1;
                            state        <= ST_R_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
`ifdef ESDI_CMD_TIMEOUT_EN
            if (to_fire) begin
                transfer_req   <= 1'b0;
                command_data   <= 1'b0;
                bit_cnt        <= '0;
                rsp_valid      <= 1'b1;
                rsp_data       <= '0;
                rsp_parity_err <= 1'b0;
                rsp_timeout_q  <= 1'b1;
                state          <= ST_DONE;
            end
`endif
        end
    end

endmodule

// File: doc/esdi_serial_cmd_initiator.md
Name: esdi_serial_cmd_initiator

Overview:
Host/controller-side end of the ESDI serial command channel, for bench and loopback testing of the drive emulator. It shifts a 16-bit command word plus odd parity out on transfer_req/command_data, handshaking each bit against transfer_ack. It then optionally clocks in a 17-bit configuration/status word on confstat_data. All cable signals are active-high at this boundary; pad inversion is done at top level.

Parameters:
SYNC_STAGES, 2, flops in the synchronizer on transfer_ack and confstat_data inputs (min 2)
SETUP_CYCLES, 8, clk cycles command_data is held stable before transfer_req rises
TIMEOUT_CYCLES, 125000, clk cycles to wait for any ack edge before abort (1 ms at 125 MHz)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command word offered
cmd_ready  out  1  block idle, accepts command
cmd_word  in  16  command word, bit 15 transmitted first
cmd_expect_rsp  in  1  after command, read a 17-bit status/config word
rsp_valid  out  1  one-cycle pulse: transaction finished
rsp_data  out  16  received word (0 if no response phase)
rsp_parity_err  out  1  received parity not odd; valid with rsp_valid
rsp_timeout  out  1  transaction aborted on timeout; valid with rsp_valid (tied 0 when feature out)
busy  out  1  transaction in progress
transfer_req  out  1  ESDI TRANSFER REQ
command_data  out  1  ESDI COMMAND DATA
transfer_ack  in  1  ESDI TRANSFER ACK (asynchronous)
confstat_data  in  1  ESDI CONFIG/STATUS DATA (asynchronous)

Behaviour:
- Reset (async assert, sync deassert in the using domain):
  - transfer_req=0, command_data=0, cmd_ready=1, busy=0.
  - rsp_valid=0, rsp_data=0, rsp_parity_err=0, rsp_timeout=0.
  - FSM=IDLE, synchronizers cleared.
- Handshake: accept when cmd_valid&&cmd_ready. Latch {cmd_word, ~^cmd_word} as 17-bit shift register; odd parity, bit 16 is parity, sent last. Latch cmd_expect_rsp. cmd_ready=0 from next cycle until the cycle after rsp_valid.
- ack_s and cfg_s are the synchronized inputs. All edge decisions use ack_s only.
- FSM:
  - IDLE: on accept -> C_SETUP, bit counter=0.
  - C_SETUP: drive command_data=current bit; count SETUP_CYCLES; -> C_REQ.
  - C_REQ: transfer_req=1; wait ack_s=1 -> C_REL.
  - C_REL: transfer_req=0; wait ack_s=0. If counter=16 -> R_REQ when expect_rsp, else DONE. Otherwise shift, counter+1, -> C_SETUP.
  - R_REQ: transfer_req=1, command_data=0; wait ack_s=1, then sample cfg_s into rx shift register (MSB first) -> R_REL.
  - R_REL: transfer_req=0; wait ack_s=0. After 17th bit -> DONE, else -> R_REQ.
  - DONE: pulse rsp_valid for 1 cycle. rsp_data=rx[16:1]. rsp_parity_err=~^rx[16:0] (1 if count of ones is even). -> IDLE.
- cfg_s is sampled in the same cycle ack_s is first seen high. Data and ack share synchronizer depth, so data is stable.
- If ack_s is already 1 on entry to C_REQ/R_REQ, it is taken as the ack. Any stuck-high ack is caught in the following *_REL wait.
- rsp_* hold their values until the next rsp_valid.
- cmd_valid while busy is ignored; no queuing.
- Bit counter is 5 bits and saturates-resets at 17; no wrap.
- Reset mid-transaction drops transfer_req within the async reset assertion. There is no partial-word resume.

Optional Feature:
ESDI_CMD_TIMEOUT_EN
- Defined:
  - A counter restarts on every state entry. In C_REQ, C_REL, R_REQ and R_REL, reaching TIMEOUT_CYCLES-1 forces transfer_req=0 and -> DONE.
  - DONE then gives rsp_timeout=1, rsp_data=0, rsp_parity_err=0.
- Undefined: no counter; waits forever; rsp_timeout tied 0.

Decomposition:
- Package esdi_pkg holds:
  - FSM state enum.
  - Constant ESDI_SERIAL_BITS=17.
  - Parity function (odd) shared with the drive-side receiver.
- One sub-module, esdi_sync: SYNC_STAGES-deep bit synchronizer with async active-low clear. Instantiated twice.

Test Plan:
- cmd_word=16'h0000, expect_rsp=0 -> 17 req/ack cycles, command_data bits 0×16 then parity 1; rsp_valid with rsp_data=0, no errors.
- cmd_word=16'h8000, expect_rsp=1; responder returns 16'hA5C3 + parity 1 -> command bits 1,0×15,0; rsp_data=16'hA5C3, rsp_parity_err=0.
- Same as previous, but responder sends parity 0 -> rsp_parity_err=1, rsp_data=16'hA5C3.
- Responder delays ack by 37 cycles per bit -> transfer_req never falls before ack_s=1; command_data constant across each req high; no timeout.
- With ESDI_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100, responder never acks -> transfer_req falls after 100 cycles; rsp_valid with rsp_timeout=1; cmd_ready=1 next cycle.
- reset_n asserted during bit 9 -> transfer_req=0 and cmd_ready=1 asynchronously. A new command after release starts at bit 15 with a correct 17-bit frame.
